// File: rtl/path_bist_ctrl.sv
// Stimulus/response BIST controller for a registered-I/O timing path: LFSR-driven a/b launch,
// LAT-delayed capture of y into a MISR, and a golden-signature pass/fail at the end of each run.
module path_bist_ctrl #(
  parameter int           W        = 16,
  parameter logic [W-1:0] POLY     = 16'hB400,
  parameter logic [W-1:0] SEED     = 16'hACE1,
  parameter int           PATTERNS = 1024,
  parameter int           LAT      = 2,
  parameter logic [W-1:0] GOLDEN   = 16'h0000
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  output logic         o_a,
  output logic         o_b,
  input  logic         i_y,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_pass,
  output logic [W-1:0] o_signature,
  output logic [31:0]  o_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [W-1:0]     r_lfsr;
  logic [W-1:0]     r_misr;
  logic             r_a;
  logic             r_b;
  logic [LAT-1:0]   r_pipe;
  logic [31:0]      r_cnt;
  logic [31:0]      r_count;
  logic             w_init;
  logic             w_capture;

  function automatic logic [W-1:0] step(input logic [W-1:0] r);
    return (r >> 1) ^ (r[0] ? POLY : '0);
  endfunction

  always_comb begin
    w_next_state = r_state;
    w_init       = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_next_state = S_RUN;
          w_init       = 1'b1;
        end
      end
      S_RUN:   if (r_cnt == 32'(PATTERNS - 1)) w_next_state = S_DRAIN;
      S_DRAIN: if (r_cnt == 32'(LAT - 1))      w_next_state = S_DONE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // The pipe tail marks which edges carry a response to an earlier launch.
  assign w_capture = ((r_state == S_RUN) || (r_state == S_DRAIN)) && r_pipe[LAT-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_lfsr  <= SEED;
      r_misr  <= '0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_pipe  <= '0;
      r_cnt   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_init) begin
        r_lfsr  <= SEED;
        r_misr  <= '0;
        r_pipe  <= '0;
        r_cnt   <= '0;
        r_count <= '0;
      end else begin
        if (r_state == S_RUN) begin
          r_a    <= r_lfsr[0];
          r_b    <= r_lfsr[1];
          r_lfsr <= step(r_lfsr);
          r_pipe <= (r_pipe << 1) | LAT'(1);
          r_cnt  <= (r_cnt == 32'(PATTERNS - 1)) ? 32'd0 : r_cnt + 32'd1;
        end else if (r_state == S_DRAIN) begin
          r_pipe <= r_pipe << 1;
          r_cnt  <= r_cnt + 32'd1;
        end
        if (w_capture) begin
          r_misr <= step(r_misr) ^ {i_y, {(W-1){1'b0}}};
          if (r_count != 32'hFFFF_FFFF) r_count <= r_count + 32'd1;
        end
      end
    end
  end

  assign o_a         = r_a;
  assign o_b         = r_b;
  assign o_busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign o_done      = (r_state == S_DONE);
  assign o_pass      = (r_state == S_DONE) && (r_misr == GOLDEN);
  assign o_signature = r_misr;
  assign o_count     = r_count;

endmodule

// File: tb/tb_path_bist_ctrl.sv
// Directed bench for path_bist_ctrl: three instances (4 patterns / y=0, 1 pattern / selectable y,
// 1024 patterns / loopback) checked against hand values and a small LFSR/MISR model.
module tb_path_bist_ctrl;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] POLY = 16'hB400;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          n_chk = 0;
  int          n_ok  = 0;

  // s: PATTERNS=4, y tied 0
  logic        start_s = 1'b0, a_s, b_s, busy_s, done_s, pass_s;
  logic [15:0] sig_s;
  logic [31:0] cnt_s;
  // o: PATTERNS=1, y tied or looped back
  logic        start_o = 1'b0, a_o, b_o, busy_o, done_o, pass_o, y_o;
  logic        tie_o = 1'b0, loop_o = 1'b0, lb_o = 1'b0;
  logic [15:0] sig_o;
  logic [31:0] cnt_o;
  // l: PATTERNS=1024, loopback
  logic        start_l = 1'b0, a_l, b_l, busy_l, done_l, pass_l, lb_l = 1'b0;
  logic [15:0] sig_l;
  logic [31:0] cnt_l;

  always #5 clk = ~clk;

  // One flop between o_a and i_y models the 2-cycle registered path.
  always_ff @(posedge clk) begin
    lb_o <= a_o;
    lb_l <= a_l;
  end
  assign y_o = loop_o ? lb_o : tie_o;

  path_bist_ctrl #(.PATTERNS(4), .LAT(2)) dut_s (
    .i_clk(clk), .i_rst(rst), .i_start(start_s), .o_a(a_s), .o_b(b_s), .i_y(1'b0),
    .o_busy(busy_s), .o_done(done_s), .o_pass(pass_s), .o_signature(sig_s), .o_count(cnt_s));
  path_bist_ctrl #(.PATTERNS(1), .LAT(2)) dut_o (
    .i_clk(clk), .i_rst(rst), .i_start(start_o), .o_a(a_o), .o_b(b_o), .i_y(y_o),
    .o_busy(busy_o), .o_done(done_o), .o_pass(pass_o), .o_signature(sig_o), .o_count(cnt_o));
  path_bist_ctrl #(.PATTERNS(1024), .LAT(2)) dut_l (
    .i_clk(clk), .i_rst(rst), .i_start(start_l), .o_a(a_l), .o_b(b_l), .i_y(lb_l),
    .o_busy(busy_l), .o_done(done_l), .o_pass(pass_l), .o_signature(sig_l), .o_count(cnt_l));

  function automatic logic [15:0] nxt(input logic [15:0] r);
    return (r >> 1) ^ (r[0] ? POLY : 16'h0000);
  endfunction

  // Loopback signature: response k equals bit 0 of the k-th LFSR state.
  function automatic logic [15:0] model_sig(input int n);
    logic [15:0] lf = SEED;
    logic [15:0] m  = 16'h0000;
    for (int k = 0; k < n; k++) begin
      m  = nxt(m) ^ {lf[0], 15'h0000};
      lf = nxt(lf);
    end
    return m;
  endfunction

  function automatic logic [15:0] model_last_lfsr(input int n);
    logic [15:0] lf = SEED;
    for (int k = 1; k < n; k++) lf = nxt(lf);
    return lf;
  endfunction

  function automatic logic busy_of(input int sel);
    case (sel)
      0:       return busy_s;
      1:       return busy_o;
      default: return busy_l;
    endcase
  endfunction

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0:       start_s = v;
      1:       start_o = v;
      default: start_l = v;
    endcase
  endtask

  // Pulses start and returns the number of sampled busy cycles (bounded).
  task automatic run(input int sel, output int cyc);
    @(posedge clk); #1; set_start(sel, 1'b1);
    @(posedge clk); #1; set_start(sel, 1'b0);
    cyc = 0;
    while (busy_of(sel) && cyc < 5000) begin
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (a_s !== 1'b0)      $display("FAIL reset_a: got %b exp 0", a_s); else n_ok++;
    n_chk++; if (b_s !== 1'b0)      $display("FAIL reset_b: got %b exp 0", b_s); else n_ok++;
    n_chk++; if (busy_s !== 1'b0)   $display("FAIL reset_busy: got %b exp 0", busy_s); else n_ok++;
    n_chk++; if (done_s !== 1'b0)   $display("FAIL reset_done: got %b exp 0", done_s); else n_ok++;
    n_chk++; if (pass_s !== 1'b0)   $display("FAIL reset_pass: got %b exp 0", pass_s); else n_ok++;
    n_chk++; if (sig_s !== 16'h0)   $display("FAIL reset_sig: got %h exp 0000", sig_s); else n_ok++;
    n_chk++; if (cnt_s !== 32'd0)   $display("FAIL reset_count: got %0d exp 0", cnt_s); else n_ok++;
    rst = 1'b0;
  endtask

  task automatic test_zero_response();
    int cyc;
    logic [15:0] last = model_last_lfsr(4);
    run(0, cyc);
    n_chk++; if (cyc != 6)          $display("FAIL zero_busy_cycles: got %0d exp 6", cyc); else n_ok++;
    n_chk++; if (done_s !== 1'b1)   $display("FAIL zero_done: got %b exp 1", done_s); else n_ok++;
    n_chk++; if (pass_s !== 1'b1)   $display("FAIL zero_pass: got %b exp 1", pass_s); else n_ok++;
    n_chk++; if (sig_s !== 16'h0)   $display("FAIL zero_sig: got %h exp 0000", sig_s); else n_ok++;
    n_chk++; if (cnt_s !== 32'd4)   $display("FAIL zero_count: got %0d exp 4", cnt_s); else n_ok++;
    n_chk++; if (a_s !== last[0])   $display("FAIL zero_last_a: got %b exp %b", a_s, last[0]); else n_ok++;
    n_chk++; if (b_s !== last[1])   $display("FAIL zero_last_b: got %b exp %b", b_s, last[1]); else n_ok++;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (done_s !== 1'b1)   $display("FAIL zero_done_held: got %b exp 1", done_s); else n_ok++;
  endtask

  task automatic test_one_response();
    int cyc;
    tie_o = 1'b1; loop_o = 1'b0;
    run(1, cyc);
    n_chk++; if (cyc != 3)          $display("FAIL one_busy_cycles: got %0d exp 3", cyc); else n_ok++;
    n_chk++; if (sig_o !== 16'h8000) $display("FAIL one_sig: got %h exp 8000", sig_o); else n_ok++;
    n_chk++; if (cnt_o !== 32'd1)   $display("FAIL one_count: got %0d exp 1", cnt_o); else n_ok++;
    n_chk++; if (pass_o !== 1'b0)   $display("FAIL one_pass: got %b exp 0", pass_o); else n_ok++;
    n_chk++; if (a_o !== 1'b1)      $display("FAIL one_a: got %b exp 1", a_o); else n_ok++;
    n_chk++; if (b_o !== 1'b0)      $display("FAIL one_b: got %b exp 0", b_o); else n_ok++;
  endtask

  task automatic test_loopback();
    int cyc;
    logic [15:0] exp_l = model_sig(1024);
    tie_o = 1'b0; loop_o = 1'b1;
    run(1, cyc);
    n_chk++; if (sig_o !== 16'h8000) $display("FAIL loop1_sig: got %h exp 8000", sig_o); else n_ok++;
    run(2, cyc);
    n_chk++; if (cyc != 1026)       $display("FAIL loop_busy_cycles: got %0d exp 1026", cyc); else n_ok++;
    n_chk++; if (sig_l !== exp_l)   $display("FAIL loop_sig: got %h exp %h", sig_l, exp_l); else n_ok++;
    n_chk++; if (cnt_l !== 32'd1024) $display("FAIL loop_count: got %0d exp 1024", cnt_l); else n_ok++;
    n_chk++; if (pass_l !== (exp_l == 16'h0)) $display("FAIL loop_pass: got %b exp %b", pass_l, exp_l == 16'h0); else n_ok++;
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    logic [15:0] exp_l = model_sig(1024);
    @(posedge clk); #1; start_l = 1'b1;
    @(posedge clk); #1; start_l = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_chk++; if (cnt_l !== 32'd8)   $display("FAIL mid_live_count: got %0d exp 8", cnt_l); else n_ok++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_chk++; if (busy_l !== 1'b0)   $display("FAIL mid_busy: got %b exp 0", busy_l); else n_ok++;
    n_chk++; if (done_l !== 1'b0)   $display("FAIL mid_done: got %b exp 0", done_l); else n_ok++;
    n_chk++; if (cnt_l !== 32'd0)   $display("FAIL mid_count: got %0d exp 0", cnt_l); else n_ok++;
    n_chk++; if (sig_l !== 16'h0)   $display("FAIL mid_sig: got %h exp 0000", sig_l); else n_ok++;
    run(2, cyc);
    n_chk++; if (sig_l !== exp_l)   $display("FAIL mid_rerun_sig: got %h exp %h", sig_l, exp_l); else n_ok++;
    n_chk++; if (cnt_l !== 32'd1024) $display("FAIL mid_rerun_count: got %0d exp 1024", cnt_l); else n_ok++;
  endtask

  task automatic test_start_handling();
    int cyc;
    // A start pulse during RUN must not stretch or restart the run.
    @(posedge clk); #1; start_s = 1'b1;
    @(posedge clk); #1; start_s = 1'b0;
    @(posedge clk); #1; start_s = 1'b1;
    @(posedge clk); #1; start_s = 1'b0;
    cyc = 2;
    while (busy_s && cyc < 100) begin
      cyc++;
      @(posedge clk); #1;
    end
    n_chk++; if (cyc != 6)          $display("FAIL ign_busy_cycles: got %0d exp 6", cyc); else n_ok++;
    n_chk++; if (cnt_s !== 32'd4)   $display("FAIL ign_count: got %0d exp 4", cnt_s); else n_ok++;
    // Restart from DONE must fully reinitialise the signature.
    tie_o = 1'b1; loop_o = 1'b0;
    run(1, cyc);
    run(1, cyc);
    n_chk++; if (sig_o !== 16'h8000) $display("FAIL restart_sig: got %h exp 8000", sig_o); else n_ok++;
    n_chk++; if (cnt_o !== 32'd1)   $display("FAIL restart_count: got %0d exp 1", cnt_o); else n_ok++;
    // Start held high: DONE lasts one cycle before the next run begins.
    @(posedge clk); #1; start_s = 1'b1;
    cyc = 0;
    while (!done_s && cyc < 100) begin
      cyc++;
      @(posedge clk); #1;
    end
    n_chk++; if (done_s !== 1'b1)   $display("FAIL held_done: got %b exp 1", done_s); else n_ok++;
    @(posedge clk); #1;
    n_chk++; if (busy_s !== 1'b1)   $display("FAIL held_restart_busy: got %b exp 1", busy_s); else n_ok++;
    n_chk++; if (done_s !== 1'b0)   $display("FAIL held_restart_done: got %b exp 0", done_s); else n_ok++;
    start_s = 1'b0;
    cyc = 0;
    while (!done_s && cyc < 100) begin
      cyc++;
      @(posedge clk); #1;
    end
    n_chk++; if (cnt_s !== 32'd4)   $display("FAIL held_count: got %0d exp 4", cnt_s); else n_ok++;
  endtask

  initial begin
    test_reset();
    test_zero_response();
    test_one_response();
    test_loopback();
    test_reset_mid_run();
    test_start_handling();
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
